ultrasonic_scheduler: RTL and testbench
=======================================

ULTRASONIC_SCHEDULER -- requirements
Module: ultrasonic_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_SENSORS, default 3, giving the number of ultrasonic sensors served (2..4).
REQ-002 The block SHALL have parameter TRIG_CYCLES, default 1000, giving the trigger pulse length in clk cycles (10 us at 100 MHz).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1156852, giving the maximum echo-wait or echo-width count.
REQ-004 The block SHALL have parameter GUARD_CYCLES, default 6000000, giving the dead time after each measurement (60 ms).
REQ-005 The block SHALL have these ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  scheduling allowed (from line follower).
- echo  input  NUM_SENSORS  raw echo lines, asynchronous.
- trigger  output  NUM_SENSORS  sensor trigger lines.
- dist_data  output  23  echo width of the last completed measurement, in clk cycles.
- dist_id  output  2  sensor index of dist_data.
- dist_valid  output  1  one-cycle pulse when dist_data/dist_id update.
- dist_timeout  output  1  qualifies dist_valid: measurement timed out.
- threshold  input  23  obstacle threshold in clk cycles.
- obstacle  output  NUM_SENSORS  per-sensor obstacle flags.

Function
REQ-006 Each echo bit SHALL pass a 2-flop synchronizer; all echo references below mean the synchronized value.
REQ-007 The FSM SHALL have the states IDLE, TRIG, WAIT_RISE, MEASURE and GUARD, and SHALL use one 23-bit counter that clears on every state entry.
REQ-008 IDLE: when enable=1, the FSM SHALL go to TRIG for the current index cur.
REQ-009 TRIG: trigger[cur] SHALL be 1 for exactly TRIG_CYCLES cycles, and the FSM SHALL then go to WAIT_RISE. Only one trigger bit SHALL ever be high at a time.
REQ-010 WAIT_RISE: if echo[cur] is 1, the FSM SHALL go to MEASURE. If the counter reaches TIMEOUT_CYCLES first, it SHALL record a timeout and go to GUARD.
REQ-011 MEASURE: the counter SHALL increment while echo[cur] is 1. When echo falls, dist_data SHALL take the count and the FSM SHALL go to GUARD.
REQ-012 In MEASURE, if the counter reaches TIMEOUT_CYCLES while echo is still 1, dist_data SHALL be TIMEOUT_CYCLES, a timeout SHALL be recorded, and the FSM SHALL go to GUARD.
REQ-013 In the cycle of entry into GUARD, dist_valid SHALL be 1, dist_id SHALL be cur, and dist_timeout SHALL be 1 if a timeout was recorded, else 0.
REQ-014 GUARD SHALL last GUARD_CYCLES cycles. On exit, cur SHALL advance round-robin (cur = NUM_SENSORS-1 wraps to 0). The FSM SHALL go to TRIG if enable=1, else to IDLE.
REQ-015 If enable goes 0 in TRIG, WAIT_RISE or MEASURE, the FSM SHALL go to GUARD next cycle, drop trigger, and SHALL NOT pulse dist_valid. GUARD SHALL always complete.
REQ-016 The counter SHALL saturate and never wrap.
REQ-017 If echo[cur] is already 1 on entry to WAIT_RISE, the FSM SHALL go to MEASURE on the next cycle.
REQ-018 Echo activity on non-selected sensors SHALL be ignored.

Reset
REQ-019 While reset_n=0, the FSM SHALL be in IDLE, with cur=0, counter=0, trigger=0, dist_data=0, dist_id=0, dist_valid=0, dist_timeout=0 and obstacle=0.
REQ-020 Assertion of reset_n mid-measurement SHALL abort it immediately, with no dist_valid pulse. Deassertion SHALL take effect on the next clk edge.

Configuration
REQ-021 With macro ULTRASONIC_OBSTACLE_EN defined: on each dist_valid, obstacle[dist_id] SHALL be set to 1 if dist_timeout=0 and dist_data < threshold, else 0.
REQ-022 With ULTRASONIC_OBSTACLE_EN defined: obstacle bits of other sensors SHALL hold, and the flag SHALL be visible the cycle after dist_valid.
REQ-023 Without ULTRASONIC_OBSTACLE_EN: obstacle SHALL be tied to 0 and no comparator SHALL be built; the threshold port SHALL remain present and be unused.

Verification
(Bench overrides: TRIG_CYCLES=10, TIMEOUT_CYCLES=500, GUARD_CYCLES=50, NUM_SENSORS=3.)
REQ-024 Scenario: enable=1, echo[0] high 120 cycles after trigger falls -> trigger[0] high exactly 10 cycles; dist_valid pulse with dist_id=0, dist_data=120, dist_timeout=0.
REQ-025 Scenario: no echo on sensor 1 -> after 500 WAIT_RISE cycles, dist_valid with dist_id=1, dist_timeout=1; next trigger is on sensor 2, then sensor 0 (wrap).
REQ-026 Scenario: echo[2] stuck high -> dist_data=500, dist_timeout=1; the counter never wraps.
REQ-027 Scenario: enable dropped 30 cycles into MEASURE -> no dist_valid, trigger=0, 50-cycle GUARD, then IDLE.
REQ-028 Scenario: reset_n pulsed low during TRIG -> trigger falls asynchronously, all outputs 0, restart from sensor 0.
REQ-029 Scenario, ULTRASONIC_OBSTACLE_EN defined: threshold=100, widths 80 then 150 on sensor 0 -> obstacle[0]=1 then 0, with the other obstacle bits unchanged.

Source files
------------

// File: rtl/ultrasonic_scheduler.sv
// Round-robin trigger/echo scheduler for NUM_SENSORS ultrasonic rangers.
// Define ULTRASONIC_OBSTACLE_EN to build the per-sensor obstacle comparator.
module ultrasonic_scheduler #(
    parameter int NUM_SENSORS    = 3,
    parameter int TRIG_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 1156852,
    parameter int GUARD_CYCLES   = 6000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic [NUM_SENSORS-1:0] trigger,
    output logic [22:0]            dist_data,
    output logic [1:0]             dist_id,
    output logic                   dist_valid,
    output logic                   dist_timeout,
    input  logic [22:0]            threshold,
    output logic [NUM_SENSORS-1:0] obstacle
);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        GUARD
    } state_t;

    localparam logic [22:0] TRIG_LAST  = 23'(TRIG_CYCLES - 1);
    localparam logic [22:0] TMO_LAST   = 23'(TIMEOUT_CYCLES - 1);
    localparam logic [22:0] TMO_VAL    = 23'(TIMEOUT_CYCLES);
    localparam logic [22:0] GUARD_LAST = 23'(GUARD_CYCLES - 1);
    localparam logic [1:0]  CUR_LAST   = 2'(NUM_SENSORS - 1);

    state_t                 state, state_nxt;
    logic [22:0]            cnt;
    logic [1:0]             cur;
    logic [NUM_SENSORS-1:0] echo_m, echo_s;
    logic                   echo_cur;
    logic                   done, done_to, adv;
    logic [22:0]            done_data;

    assign echo_cur = echo_s[cur];
    assign trigger  = (state == TRIG)
                    ? ({{(NUM_SENSORS-1){1'b0}}, 1'b1} << cur)
                    : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            echo_m <= '0;
            echo_s <= '0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        done_to   = 1'b0;
        done_data = '0;
        adv       = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) state_nxt = TRIG;
            end
            TRIG: begin
                if (!enable) state_nxt = GUARD;
                else if (cnt >= TRIG_LAST) state_nxt = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (!enable) begin
                    state_nxt = GUARD;
                end else if (echo_cur) begin
                    state_nxt = MEASURE;
                end else if (cnt >= TMO_LAST) begin
                    state_nxt = GUARD;
                    done      = 1'b1;
                    done_to   = 1'b1;
                end
            end
            MEASURE: begin
                // the rising edge was seen in WAIT_RISE, hence the +1
                if (!enable) begin
                    state_nxt = GUARD;
                end else if (!echo_cur) begin
                    state_nxt = GUARD;
                    done      = 1'b1;
                    done_data = cnt + 23'd1;
                end else if (cnt >= TMO_LAST) begin
                    state_nxt = GUARD;
                    done      = 1'b1;
                    done_to   = 1'b1;
                    done_data = TMO_VAL;
                end
            end
            GUARD: begin
                if (cnt >= GUARD_LAST) begin
                    adv       = 1'b1;
                    state_nxt = enable ? TRIG : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            cur          <= '0;
            dist_data    <= '0;
            dist_id      <= '0;
            dist_valid   <= 1'b0;
            dist_timeout <= 1'b0;
        end else begin
            state      <= state_nxt;
            dist_valid <= done;
            if (state_nxt != state) cnt <= '0;
            else if (state != IDLE && cnt != '1) cnt <= cnt + 23'd1;
            if (adv) cur <= (cur == CUR_LAST) ? 2'd0 : cur + 2'd1;
            if (done) begin
                dist_data    <= done_data;
                dist_id      <= cur;
                dist_timeout <= done_to;
            end
        end
    end

`ifdef ULTRASONIC_OBSTACLE_EN
    logic [NUM_SENSORS-1:0] obs_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            obs_q <= '0;
        end else if (dist_valid) begin
            obs_q[dist_id] <= !dist_timeout && (dist_data < threshold);
        end
    end

    assign obstacle = obs_q;
`else
    logic unused_threshold;

    assign unused_threshold = ^threshold;
    assign obstacle         = '0;
`endif

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Self-checking bench for ultrasonic_scheduler: vector table plus
// hand-written abort, idle and reset sequences, scoreboarded results.
module tb_ultrasonic_scheduler;

    localparam int NS   = 3;
    localparam int TRIG = 10;
    localparam int TMO  = 500;
    localparam int GRD  = 50;
    localparam int THR  = 100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [NS-1:0] echo;
    logic [NS-1:0] trigger;
    logic [22:0]   dist_data;
    logic [1:0]    dist_id;
    logic          dist_valid;
    logic          dist_timeout;
    logic [22:0]   threshold;
    logic [NS-1:0] obstacle;

    always #5 clk = ~clk;

    ultrasonic_scheduler #(
        .NUM_SENSORS   (NS),
        .TRIG_CYCLES   (TRIG),
        .TIMEOUT_CYCLES(TMO),
        .GUARD_CYCLES  (GRD)
    ) dut (
        .clk         (clk),
        .reset_n     (rst_n),
        .enable      (enable),
        .echo        (echo),
        .trigger     (trigger),
        .dist_data   (dist_data),
        .dist_id     (dist_id),
        .dist_valid  (dist_valid),
        .dist_timeout(dist_timeout),
        .threshold   (threshold),
        .obstacle    (obstacle)
    );

    typedef struct {
        int id;
        int delay;
        int width;
        bit pre;
        int data;
        bit to;
        bit chk_data;
    } vec_t;

    typedef struct {
        int id;
        int data;
        bit to;
        bit chk_data;
        int fall;
    } exp_t;

    exp_t          sb[$];
    vec_t          vecs[10];
    int            passed = 0;
    int            total = 0;
    int            cyc = 0;
    int            last_valid_cyc = 0;
    int            onehot_bad = 0;
    logic [NS-1:0] exp_obs;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic pulse(input int id, input int w);
        echo[id] = 1'b1;
        repeat (w) @(negedge clk);
        echo[id] = 1'b0;
    endtask

    task automatic wait_trig(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (trigger != '0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("trig_seen", 32'(ok), 1);
    endtask

    task automatic run_vec(input vec_t v, input bit chk_guard,
                           output int t0);
        int   n;
        bit   ok;
        exp_t e;
        wait_trig(ok);
        t0 = cyc;
        if (chk_guard) check("guard_gap", 32'(cyc - last_valid_cyc), GRD);
        check("trig_id", 32'(trigger), 32'(1 << v.id));
        n = 0;
        while (trigger != '0 && n < 100) begin
            n++;
            if (v.pre && n == 7) begin
                fork
                    pulse(v.id, v.width);
                join_none
            end
            @(negedge clk);
        end
        check("trig_width", 32'(n), TRIG);
        e.id       = v.id;
        e.data     = v.data;
        e.to       = v.to;
        e.chk_data = v.chk_data;
        e.fall     = (v.width == 0) ? cyc : -1;
        if (v.width != 0 && !v.pre) begin
            repeat (v.delay) @(negedge clk);
            fork
                pulse(v.id, v.width);
            join_none
        end
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        bit   obs_pend;
        obs_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if ($countones(trigger) > 1) onehot_bad++;
`ifdef ULTRASONIC_OBSTACLE_EN
                if (obs_pend) begin
                    check("obstacle", 32'(obstacle), 32'(exp_obs));
                    obs_pend = 1'b0;
                end
`endif
                if (dist_valid) begin
                    last_valid_cyc = cyc;
                    if (sb.size() == 0) begin
                        check("unexpected_valid", 32'(dist_valid), 0);
                    end else begin
                        e = sb.pop_front();
                        check("dist_id", 32'(dist_id), e.id);
                        check("dist_timeout", 32'(dist_timeout), 32'(e.to));
                        if (e.chk_data) check("dist_data", 32'(dist_data), e.data);
                        if (e.fall >= 0) check("wait_rise_timeout", 32'(cyc - e.fall), TMO);
`ifdef ULTRASONIC_OBSTACLE_EN
                        exp_obs[e.id] = !e.to && (e.data < THR);
                        obs_pend      = 1'b1;
`else
                        check("obstacle_off", 32'(obstacle), 0);
`endif
                    end
                end
            end
        end
    end

    initial begin
        int   t0, rel, n;
        bit   ok;
        vec_t v;
        rst_n     = 1'b0;
        enable    = 1'b0;
        echo      = '0;
        threshold = 23'(THR);
        exp_obs   = '0;
        // id, delay, width, pre, data, timeout, chk_data
        vecs[0] = '{0, 5, 120, 1'b0, 120, 1'b0, 1'b1};
        vecs[1] = '{1, 0, 0,   1'b0, 0,   1'b1, 1'b0};
        vecs[2] = '{2, 5, 700, 1'b0, 500, 1'b1, 1'b1};
        vecs[3] = '{0, 0, 82,  1'b1, 80,  1'b0, 1'b1};
        vecs[4] = '{1, 5, 1,   1'b0, 1,   1'b0, 1'b1};
        vecs[5] = '{2, 5, 500, 1'b0, 500, 1'b0, 1'b1};
        vecs[6] = '{0, 5, 501, 1'b0, 500, 1'b1, 1'b1};
        vecs[7] = '{1, 3, 80,  1'b0, 80,  1'b0, 1'b1};
        vecs[8] = '{2, 20, 37, 1'b0, 37,  1'b0, 1'b1};
        vecs[9] = '{0, 5, 150, 1'b0, 150, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_trigger", 32'(trigger), 0);
        check("rst_valid", 32'(dist_valid), 0);
        check("rst_data", 32'(dist_data), 0);
        check("rst_id", 32'(dist_id), 0);
        check("rst_timeout", 32'(dist_timeout), 0);
        check("rst_obstacle", 32'(obstacle), 0);
        rst_n  = 1'b1;
        enable = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i != 0, t0);

        // enable dropped mid-measurement, then left low
        wait_trig(ok);
        check("abort_a_id", 32'(trigger), 2);
        n = 0;
        while (trigger != '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        fork
            pulse(1, 200);
        join_none
        repeat (33) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_a_trig", 32'(trigger), 0);
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (trigger != '0) n++;
        end
        check("idle_quiet", 32'(n), 0);
        enable = 1'b1;
        @(negedge clk);
        check("idle_restart_id", 32'(trigger), 4);

        // enable dropped in TRIG; guard completes although enable returns
        repeat (2) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_b_trig", 32'(trigger), 0);
        n = 1;
        while (trigger == '0 && n < 200) begin
            if (n == 20) enable = 1'b1;
            @(negedge clk);
            n++;
        end
        check("abort_guard_len", 32'(n), GRD + 1);
        check("abort_wrap_id", 32'(trigger), 1);

        // asynchronous reset during TRIG
        repeat (2) @(negedge clk);
        #2;
        rst_n   = 1'b0;
        exp_obs = '0;
        #1;
        check("arst_trigger", 32'(trigger), 0);
        check("arst_data", 32'(dist_data), 0);
        check("arst_valid", 32'(dist_valid), 0);
        check("arst_obstacle", 32'(obstacle), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rel   = cyc;
        v     = '{0, 5, 60, 1'b0, 60, 1'b0, 1'b1};
        run_vec(v, 1'b0, t0);
        check("restart_latency", 32'(t0 - rel), 1);

        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", 32'(sb.size()), 0);
        repeat (3) @(negedge clk);
        check("onehot_trigger", 32'(onehot_bad), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
